// File: rtl/vjtag_host_seq.sv
// Host sequencer for a virtual-JTAG responder clocked on the same clk: optional IR load,
// then capture, an LSB-first DR scan of N bits, update, and a held 8-bit response.
module vjtag_host_seq (
  input  logic        clk,
  input  logic        aclr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [2:0]  ir_in,
  output logic        v_uir,
  output logic        v_cdr,
  output logic        v_sdr,
  output logic        v_udr,
  output logic        tdi,
  input  logic        tdo
);

  localparam logic [1:0] OP_REG = 2'd0;
  localparam logic [1:0] OP_MRD = 2'd1;
  localparam logic [1:0] OP_MWR = 2'd2;
  localparam logic [1:0] OP_BYP = 2'd3;

  localparam logic [2:0] IR_BYP = 3'b000;
  localparam logic [2:0] IR_REG = 3'b001;
  localparam logic [2:0] IR_RD  = 3'b010;
  localparam logic [2:0] IR_WR  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IR = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_UPDATE  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ir_valid;
  logic [2:0]  r_ir;
  logic [4:0]  r_len_m1;
  logic [4:0]  r_cnt;
  logic [25:0] r_tx;
  logic [7:0]  r_rx;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic        r_v_uir;
  logic        r_v_cdr;
  logic        r_v_sdr;
  logic        r_v_udr;
  logic        r_tdi;

  logic        w_accept;
  logic        w_ir_hit;
  logic        w_last_bit;
  logic [2:0]  w_ir_code;
  logic [4:0]  w_len_m1;
  logic [26:0] w_tx;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_ir_hit   = r_ir_valid && (r_ir == w_ir_code);
  assign w_last_bit = (r_cnt == r_len_m1);

  // Instruction code, scan length minus one and TX vector for the presented request
  always_comb begin
    w_ir_code = IR_BYP;
    w_len_m1  = 5'd2;
    w_tx      = 27'd0;
    case (req_op)
      OP_REG: begin
        w_ir_code = IR_REG;
        w_len_m1  = 5'd15;
        w_tx      = {11'd0, 4'h0, req_addr[3:0], req_data};
      end
      OP_MRD: begin
        w_ir_code = IR_RD;
        w_len_m1  = 5'd26;
        w_tx      = {req_addr, req_data};
      end
      OP_MWR: begin
        w_ir_code = IR_WR;
        w_len_m1  = 5'd26;
        w_tx      = {req_addr, req_data};
      end
      OP_BYP: begin
        w_ir_code = IR_BYP;
        w_len_m1  = 5'd2;
        w_tx      = {24'd0, req_data[2:0]};
      end
      default: begin
        w_ir_code = IR_BYP;
        w_len_m1  = 5'd2;
        w_tx      = 27'd0;
      end
    endcase
  end

  // Next-state logic; the IR load is skipped when the target already holds the code
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_ir_hit) begin
            w_state_nxt = S_CAPTURE;
          end else begin
            w_state_nxt = S_LOAD_IR;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD_IR: w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = S_UPDATE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_UPDATE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobes and handshakes are decoded from the next state so they are glitch-free flops
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_v_uir     <= 1'b0;
      r_v_cdr     <= 1'b0;
      r_v_sdr     <= 1'b0;
      r_v_udr     <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_v_uir     <= (w_state_nxt == S_LOAD_IR);
      r_v_cdr     <= (w_state_nxt == S_CAPTURE);
      r_v_sdr     <= (w_state_nxt == S_SHIFT);
      r_v_udr     <= (w_state_nxt == S_UPDATE);
    end
  end

  // Request latch, serial TX/RX and response register
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_ir_valid <= 1'b0;
      r_ir       <= 3'b000;
      r_len_m1   <= 5'd0;
      r_cnt      <= 5'd0;
      r_tx       <= 26'd0;
      r_rx       <= 8'd0;
      r_tdi      <= 1'b0;
      r_rsp_data <= 8'd0;
    end else if (w_accept) begin
      r_ir     <= w_ir_code;
      r_len_m1 <= w_len_m1;
      r_cnt    <= 5'd0;
      r_tx     <= w_tx[26:1];
      r_tdi    <= w_tx[0];
      r_rx     <= 8'd0;
    end else if (r_state == S_LOAD_IR) begin
      r_ir_valid <= 1'b1;
    end else if (r_state == S_SHIFT) begin
      // tdo still shows the pre-shift target bit at this edge
      if (r_cnt < 5'd8) begin
        r_rx[r_cnt[2:0]] <= tdo;
      end
      r_cnt <= r_cnt + 5'd1;
      r_tx  <= {1'b0, r_tx[25:1]};
      r_tdi <= w_last_bit ? 1'b0 : r_tx[0];
    end else if (r_state == S_UPDATE) begin
      r_rsp_data <= r_rx;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign ir_in     = r_ir;
  assign v_uir     = r_v_uir;
  assign v_cdr     = r_v_cdr;
  assign v_sdr     = r_v_sdr;
  assign v_udr     = r_v_udr;
  assign tdi       = r_tdi;

endmodule
